// File: rtl/matrix_accel_pkg.sv
// Shared definitions for the matrix accelerator: loader states, SRAM layout
// defaults, Avalon byte-enable constant and the float32 word type.
package matrix_accel_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SIZE_W     = 16;
  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_A_BASE = 8;
  localparam int unsigned DEF_B_BASE = 4096;

  // Header words sit at the bottom of the SRAM image
  localparam int unsigned HDR0_ADDR = 0;
  localparam int unsigned HDR1_ADDR = 4;

  localparam logic [3:0] MM_BYTEEN_ALL = 4'hF;

  typedef logic [WORD_W-1:0] float32_t;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] loader_state_t;

  localparam loader_state_t ST_IDLE      = 3'd0;
  localparam loader_state_t ST_HDR0      = 3'd1;
  localparam loader_state_t ST_HDR1      = 3'd2;
  localparam loader_state_t ST_LOAD_A    = 3'd3;
  localparam loader_state_t ST_LOAD_B    = 3'd4;
  localparam loader_state_t ST_START     = 3'd5;
  localparam loader_state_t ST_WAIT_DONE = 3'd6;

endpackage

// File: rtl/avm_write_port.sv
// Single-outstanding Avalon-MM write master: registers address/data on a
// request and holds them until the slave drops waitrequest.
module avm_write_port
  import matrix_accel_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  float32_t          data_i,
  input  logic              waitrequest_i,
  output logic [ADDR_W-1:0] address_o,
  output logic              chipselect_o,
  output logic              write_o,
  output float32_t          writedata_o,
  output logic [3:0]        byteenable_o,
  output logic              done_c_o,
  output logic              idle_o
);

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  float32_t          data_q, data_d;

  // A new request may replace a write in the same cycle it completes
  always_comb begin
    write_d = write_q & waitrequest_i;
    addr_d  = addr_q;
    data_d  = data_q;
    if (req_i) begin
      write_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign address_o    = addr_q;
  assign writedata_o  = data_q;
  assign write_o      = write_q;
  assign chipselect_o = write_q;
  assign byteenable_o = write_q ? MM_BYTEEN_ALL : 4'h0;
  assign done_c_o     = write_q & ~waitrequest_i;
  assign idle_o       = ~write_q;

endmodule

// File: rtl/matrix_sram_loader.sv
// Loads size header plus matrices A and B into the multiplier SRAM, then
// kicks the multiplier and waits for it. Build option: SIZE_CHECK_EN.
module matrix_sram_loader
  import matrix_accel_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned A_BASE = DEF_A_BASE,
  parameter int unsigned B_BASE = DEF_B_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_size_a,
  input  logic [15:0]       cfg_size_b,
  input  logic [15:0]       cfg_size_c,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              mult_start,
  input  logic              mult_valid,
  output logic              busy,
  output logic              error
);

  loader_state_t     state_q, state_d;
  logic [SIZE_W-1:0] size_a_q, size_a_d, size_b_q, size_b_d, size_c_q, size_c_d;
  logic [31:0]       n_a_q, n_a_d, n_b_q, n_b_d, idx_q, idx_d;
  logic              cfg_ready_q, cfg_ready_d, s_ready_q, s_ready_d;
  logic              busy_q, busy_d, mult_start_q, mult_start_d;

  logic              cfg_hs, s_hs, reject;
  logic              wr_req, wr_done, wr_idle, wr_hold;
  logic [ADDR_W-1:0] wr_addr;
  float32_t          wr_data;
  logic [31:0]       prod_a, prod_b, n_cur, base_cur, addr_full;

  assign cfg_hs  = cfg_valid & cfg_ready_q;
  assign s_hs    = s_valid & s_ready_q;
  assign prod_a  = 32'(cfg_size_a) * 32'(cfg_size_b);
  assign prod_b  = 32'(cfg_size_b) * 32'(cfg_size_c);
  assign wr_hold = ~wr_idle & ~wr_done;

`ifdef SIZE_CHECK_EN
  localparam int unsigned A_CAP = (B_BASE - A_BASE) / 4;
  localparam int unsigned B_CAP = ((32'd1 << ADDR_W) - B_BASE) / 4;

  logic error_q;

  assign reject = (cfg_size_a == '0) | (cfg_size_b == '0) | (cfg_size_c == '0) |
                  (prod_a > A_CAP) | (prod_b > B_CAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= cfg_hs & reject;
  end

  assign error = error_q;
`else
  assign reject = 1'b0;
  assign error  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    size_a_d  = size_a_q;
    size_b_d  = size_b_q;
    size_c_d  = size_c_q;
    n_a_d     = n_a_q;
    n_b_d     = n_b_q;
    idx_d     = idx_q;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    n_cur     = (state_q == ST_LOAD_B) ? n_b_q : n_a_q;
    base_cur  = (state_q == ST_LOAD_B) ? 32'(B_BASE) : 32'(A_BASE);
    addr_full = base_cur + (idx_q << 2);

    case (state_q)
      ST_IDLE: begin
        if (cfg_hs && !reject) begin
          size_a_d = cfg_size_a;
          size_b_d = cfg_size_b;
          size_c_d = cfg_size_c;
          n_a_d    = prod_a;
          n_b_d    = prod_b;
          state_d  = ST_HDR0;
        end
      end
      ST_HDR0: begin
        // Port is idle only on entry; the second header follows the first
        if (wr_idle) begin
          wr_req  = 1'b1;
          wr_addr = ADDR_W'(HDR0_ADDR);
          wr_data = {size_b_q, size_a_q};
        end else if (wr_done) begin
          wr_req  = 1'b1;
          wr_addr = ADDR_W'(HDR1_ADDR);
          wr_data = {16'h0, size_c_q};
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (wr_done) state_d = ST_LOAD_A;
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (s_hs) begin
          wr_req  = 1'b1;
          wr_addr = ADDR_W'(addr_full);
          wr_data = s_data;
        end
        if (wr_done) idx_d = idx_q + 32'd1;
        // Leave as soon as the last write retires; empty phases pass straight through
        if (!s_hs && !wr_hold && (idx_d == n_cur)) begin
          idx_d   = '0;
          state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mult_valid) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    cfg_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    mult_start_d = (state_d == ST_START);
    s_ready_d    = ~(wr_req | wr_hold) &
                   (((state_d == ST_LOAD_A) & (idx_d < n_a_q)) |
                    ((state_d == ST_LOAD_B) & (idx_d < n_b_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      size_a_q     <= '0;
      size_b_q     <= '0;
      size_c_q     <= '0;
      n_a_q        <= '0;
      n_b_q        <= '0;
      idx_q        <= '0;
      cfg_ready_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      mult_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_a_q     <= size_a_d;
      size_b_q     <= size_b_d;
      size_c_q     <= size_c_d;
      n_a_q        <= n_a_d;
      n_b_q        <= n_b_d;
      idx_q        <= idx_d;
      cfg_ready_q  <= cfg_ready_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      mult_start_q <= mult_start_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign mult_start = mult_start_q;

  avm_write_port #(.ADDR_W(ADDR_W)) u_wr (
    .clk          (clk),
    .rst          (rst),
    .req_i        (wr_req),
    .addr_i       (wr_addr),
    .data_i       (wr_data),
    .waitrequest_i(avm_waitrequest),
    .address_o    (avm_address),
    .chipselect_o (avm_chipselect),
    .write_o      (avm_write),
    .writedata_o  (avm_writedata),
    .byteenable_o (avm_byteenable),
    .done_c_o     (wr_done),
    .idle_o       (wr_idle)
  );

endmodule

// File: tb/tb_matrix_sram_loader.sv
// Scoreboard bench for matrix_sram_loader: expected SRAM writes are queued as
// stimulus is driven and retired as the Avalon slave model accepts them.
module tb_matrix_sram_loader;

  localparam int A_B = 8;
  localparam int B_B = 4096;

  logic        clk, rst;
  logic        cfg_valid, cfg_ready;
  logic [15:0] cfg_size_a, cfg_size_b, cfg_size_c;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [13:0] avm_address;
  logic        avm_chipselect, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        mult_start, mult_valid, busy, error;

  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  stall_n = 0;
  int  cyc = 0;
  int  last_done = 0;
  int  start_cnt = 0;
  int  ld_start0 = 0;
  int  wr_cnt = 0;

  matrix_sram_loader dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_size_a     (cfg_size_a),
    .cfg_size_b     (cfg_size_b),
    .cfg_size_c     (cfg_size_c),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .mult_start     (mult_start),
    .mult_valid     (mult_valid),
    .busy           (busy),
    .error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Avalon slave model: stalls each write stall_n cycles, retires it against the scoreboard
  initial begin
    int   stall_cnt;
    logic prev_ms;
    logic [13:0] hold_a;
    logic [31:0] hold_d;
    wr_t  e;
    stall_cnt = 0;
    prev_ms = 1'b0;
    hold_a = '0;
    hold_d = '0;
    avm_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mult_start) begin
        chk("start_latency", 64'(cyc), 64'(last_done + 1));
        chk("start_pulse_width", 64'(prev_ms), 64'd0);
        start_cnt++;
      end
      prev_ms = mult_start;
      if (avm_write) begin
        chk("s_ready_while_pending", 64'(s_ready), 64'd0);
        if (stall_cnt == 0) begin
          hold_a = avm_address;
          hold_d = avm_writedata;
        end else begin
          chk("hold_addr", 64'(avm_address), 64'(hold_a));
          chk("hold_data", 64'(avm_writedata), 64'(hold_d));
        end
        if (stall_cnt < stall_n) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          wr_cnt++;
          last_done = cyc;
          chk("wr_cs_be", 64'({avm_chipselect, avm_byteenable}), 64'h1F);
          if (sb.size() == 0) begin
            chk("unexpected_write_addr", 64'(avm_address), 64'h3FFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(avm_address), 64'(e.a));
            chk("wr_data", 64'(avm_writedata), 64'(e.d));
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt = 0;
        chk("idle_cs_be", 64'({avm_chipselect, avm_byteenable}), 64'd0);
      end
    end
  end

  task automatic send_cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input bit ok);
    int n;
    ld_start0 = start_cnt;
    if (ok) begin
      sb.push_back('{a: 14'd0, d: {b, a}});
      sb.push_back('{a: 14'd4, d: {16'h0, c}});
    end
    cfg_size_a = a;
    cfg_size_b = b;
    cfg_size_c = c;
    cfg_valid  = 1'b1;
    n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_error", 64'(error), 64'(!ok));
    chk("cfg_busy", 64'(busy), 64'(ok));
  endtask

  task automatic send_mat(input int base, input int first, input int cnt, input bit gap);
    int n;
    logic [31:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      sb.push_back('{a: 14'(base + 4 * (first + i)), d: w});
      s_data  = w;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (start_cnt == ld_start0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("start_count", 64'(start_cnt - ld_start0), 64'd1);
    repeat (2) @(negedge clk);
    chk("wait_done_busy", 64'(busy), 64'd1);
  endtask

  task automatic release_mult();
    mult_valid = 1'b1;
    @(negedge clk);
    mult_valid = 1'b0;
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_size_a = '0;
    cfg_size_b = '0;
    cfg_size_c = '0;
    s_data = '0;
    s_valid = 1'b0;
    mult_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({cfg_ready, s_ready, mult_start, busy, error}), 64'd0);
    chk("rst_avm", 64'({avm_address, avm_writedata, avm_chipselect, avm_write, avm_byteenable}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic 2x3 * 3x2 load, no stalls
    stall_n = 0;
    send_cfg(16'd2, 16'd3, 16'd2, 1'b1);
    send_mat(A_B, 0, 6, 1'b0);
    send_mat(B_B, 0, 6, 1'b0);
    wait_start();
    release_mult();

    // Same load, every write stalled 3 cycles
    stall_n = 3;
    send_cfg(16'd2, 16'd3, 16'd2, 1'b1);
    send_mat(A_B, 0, 6, 1'b0);
    send_mat(B_B, 0, 6, 1'b0);
    wait_start();
    release_mult();

    // 1x1x1 with s_valid toggling
    stall_n = 0;
    wr_cnt = 0;
    send_cfg(16'd1, 16'd1, 16'd1, 1'b1);
    send_mat(A_B, 0, 1, 1'b1);
    send_mat(B_B, 0, 1, 1'b1);
    wait_start();
    chk("t3_write_count", 64'(wr_cnt), 64'd4);
    release_mult();

    // Descriptor and mult_valid outside their states are ignored
    send_cfg(16'd2, 16'd3, 16'd2, 1'b1);
    send_mat(A_B, 0, 2, 1'b0);
    cfg_size_a = 16'd7;
    cfg_size_b = 16'd7;
    cfg_size_c = 16'd7;
    cfg_valid  = 1'b1;
    mult_valid = 1'b1;
    chk("load_cfg_ready", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    cfg_valid  = 1'b0;
    mult_valid = 1'b0;
    chk("load_busy", 64'(busy), 64'd1);
    send_mat(A_B, 2, 4, 1'b0);
    send_mat(B_B, 0, 6, 1'b0);
    wait_start();
    cfg_valid = 1'b1;
    chk("wait_cfg_ready", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("wait_busy_after_cfg", 64'(busy), 64'd1);
    release_mult();

    // Reset in the middle of a stalled B write
    send_cfg(16'd1, 16'd1, 16'd1, 1'b1);
    send_mat(A_B, 0, 1, 1'b0);
    @(negedge clk);
    stall_n = 1000;
    send_mat(B_B, 0, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_stalled_write", 64'(avm_write), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", 64'({cfg_ready, s_ready, mult_start, busy, error}), 64'd0);
    chk("t5_rst_avm", 64'({avm_chipselect, avm_write, avm_byteenable}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    stall_n = 0;
    @(negedge clk);
    chk("t5_idle_ready", 64'(cfg_ready), 64'd1);
    send_cfg(16'd1, 16'd2, 16'd1, 1'b1);
    send_mat(A_B, 0, 2, 1'b0);
    send_mat(B_B, 0, 2, 1'b0);
    wait_start();
    release_mult();

`ifdef SIZE_CHECK_EN
    wr_cnt = 0;
    send_cfg(16'd32, 16'd32, 16'd1, 1'b0);
    @(negedge clk);
    chk("rej_err_pulse", 64'(error), 64'd0);
    send_cfg(16'd0, 16'd4, 16'd4, 1'b0);
    repeat (4) @(negedge clk);
    chk("rej_idle", 64'({busy, error, cfg_ready}), 64'd1);
    chk("rej_no_writes", 64'(wr_cnt), 64'd0);
`else
    // Oversized A spills past the B base; empty A phase is skipped
    send_cfg(16'd32, 16'd32, 16'd1, 1'b1);
    send_mat(A_B, 0, 1024, 1'b0);
    send_mat(B_B, 0, 32, 1'b0);
    wait_start();
    release_mult();
    send_cfg(16'd0, 16'd4, 16'd4, 1'b1);
    send_mat(B_B, 0, 16, 1'b0);
    wait_start();
    release_mult();
`endif

    repeat (3) @(negedge clk);
    chk("sb_final", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_sram_loader.md
Name: matrix_sram_loader

Overview:
Upstream feeder for the matrix multiplier accelerator. It accepts a size descriptor and a stream of 32-bit float words for matrices A and B, then writes them through an Avalon-MM master into the shared on-chip SRAM in the layout the multiplier reads:
- byte 0: header word {SIZE_B, SIZE_A}
- byte 4: header word {16'h0, SIZE_C}
- A_BASE: matrix A
- B_BASE: matrix B

Once the load completes it pulses mult_start, then holds off further loads until the multiplier reports mult_valid.

Parameters:
ADDR_W, 14, Avalon byte-address width
A_BASE, 8, byte address of A[0] (row-major, word-aligned)
B_BASE, 4096, byte address of B[0] (row-major, word-aligned)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_valid  in  1  size descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
cfg_size_a  in  16  rows of A
cfg_size_b  in  16  cols of A = rows of B
cfg_size_c  in  16  cols of B
s_data  in  32  matrix word (A words first, then B words)
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid & s_ready
avm_address  out  ADDR_W  byte address
avm_chipselect  out  1  asserted with avm_write
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  always 4'hF during writes, 4'h0 otherwise
avm_waitrequest  in  1  slave stall
mult_start  out  1  one-cycle pulse, load complete
mult_valid  in  1  multiplier finished
busy  out  1  high whenever state != IDLE
error  out  1  one-cycle pulse on rejected descriptor (SIZE_CHECK_EN only)

Behaviour:
Reset values: all outputs 0; state IDLE; counters 0.

Descriptor latching:
- In IDLE, cfg_ready=1.
- On handshake, register the sizes.
- n_a = size_a*size_b and n_b = size_b*size_c are computed as 32-bit products and registered.

State sequence, IDLE -> HDR0 -> HDR1 -> LOAD_A -> LOAD_B -> START -> WAIT_DONE -> IDLE:
- HDR0: write {size_b, size_a} to address 0.
- HDR1: write {16'h0, size_c} to address 4.
- LOAD_A / LOAD_B:
  - s_ready=1 only while no write is pending (single outstanding write, no skid).
  - An accepted word is registered and its write is issued on the next cycle.
  - Address is A_BASE + 4*idx or B_BASE + 4*idx.
  - idx increments on write completion.
  - The phase exits once idx == n_x with no write pending; idx clears on exit.
  - n_x == 0 skips the phase without accepting words.
- START: mult_start=1 for exactly one cycle.
- WAIT_DONE: stay until mult_valid=1; mult_valid is ignored in all other states.

Write handshake:
- A write completes in a cycle where avm_write=1 and avm_waitrequest=0.
- Address, data and write are held stable while waitrequest=1.
- Back-to-back throughput is one word per 2 cycles minimum.

Address arithmetic: truncate to ADDR_W, i.e. wrap modulo 2^ADDR_W.

Boundary cases:
- cfg_valid outside IDLE is not acknowledged.
- s_valid in IDLE, HDR*, START or WAIT_DONE is not acknowledged.
- rst mid-load aborts immediately to IDLE with outputs at reset values; partially written SRAM contents are left undefined.

Optional Feature:
SIZE_CHECK_EN
- With the macro, a descriptor is accepted but rejected (error=1 for one cycle, stay IDLE, no writes) if any of these hold:
  - any size == 0
  - n_a > (B_BASE-A_BASE)/4, i.e. 1022 words
  - n_b > (2^ADDR_W - B_BASE)/4, i.e. 3072 words
- Without the macro: error is tied 0, sizes are unchecked, addresses wrap per the arithmetic rule, and zero-count phases are skipped.

Decomposition:
Shared package matrix_accel_pkg holds:
- loader state enum
- HDR0_ADDR and HDR1_ADDR
- default A_BASE/B_BASE
- MM_BYTEEN_ALL = 4'hF
- the float32 word typedef

One sub-module is natural: avm_write_port. It holds a single pending write and its registered address/data and waitrequest hold, and reports done/idle to the loader FSM.

Test Plan:
1. Sizes 2,3,2; 6 A words then 6 B words; waitrequest=0 -> writes at 0 ({3,2}), 4 (2), 8..28, 4096..4116 in order; one mult_start pulse; busy stays high until mult_valid.
2. Same load with waitrequest=1 for 3 cycles on every write -> address/data held stable throughout; no stream word lost; s_ready=0 while a write is pending.
3. Sizes 1,1,1; s_valid toggling every other cycle -> exactly 4 writes, A at 8 and B at 4096; mult_start fires 1 cycle after the last write completes.
4. cfg_valid pulsed during LOAD_A and during WAIT_DONE -> cfg_ready=0 and descriptor ignored; after mult_valid, a fresh descriptor is accepted in IDLE.
5. rst asserted mid-LOAD_B with waitrequest=1 -> avm_write drops asynchronously; all outputs 0; state IDLE; next descriptor restarts at HDR0.
6. SIZE_CHECK_EN, sizes 32,32,1 (n_a=1024 > 1022) -> error pulse, no writes, busy=0; sizes 0,4,4 -> error pulse; without the macro, sizes 32,32,1 loads with A addresses wrapping past byte 4092 into the B region.
